// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single synchronous write port of the register-file memory between the ALU
//   writeback (requester 0) and the load/CSR writeback (requester 1). Arbitration is
//   round-robin with a valid/ready handshake. The write controls to the memory are registered,
//   so an accepted write reaches the memory one cycle after its handshake. A sequenced clear
//   zeroes every entry, one per cycle. With ZERO_PROT set, writes to address 0 are accepted
//   but dropped, which gives x0 its hard-wired-zero behaviour.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   req0_valid/ready/addr/data   requester 0 write handshake
//   req1_valid/ready/addr/data   requester 1 write handshake
//   clr_req                      single-cycle request to zero the whole memory
//   busy                         clear sweep in progress
//   clr_done                     pulse during the cycle driving the last clear write
//   mem_we/mem_wr_addr/mem_wr_din  registered write controls to the memory
module regfile_wr_arbiter #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 32,
   parameter bit          ZERO_PROT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [$clog2(DEPTH)-1:0] req0_addr,
   input  logic [WIDTH-1:0]         req0_data,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [$clog2(DEPTH)-1:0] req1_addr,
   input  logic [WIDTH-1:0]         req1_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done,
   output logic                     mem_we,
   output logic [$clog2(DEPTH)-1:0] mem_wr_addr,
   output logic [WIDTH-1:0]         mem_wr_din
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   localparam logic [0:0] StRun   = 1'b0;
   localparam logic [0:0] StClear = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0] din_q, din_d;

   logic             in_run;
   logic             grant0, grant1;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_data;

   // Round-robin: on contention the requester that did not win last time gets the port.
   always_comb begin
      in_run = (state_q == StRun);
      grant0 = in_run && !clr_req && req0_valid && (!req1_valid || last_grant_q);
      grant1 = in_run && !clr_req && req1_valid && (!req0_valid || !last_grant_q);
   end

   // Readys are forced low while reset is held, independent of the registered state.
   assign req0_ready = rst & grant0;
   assign req1_ready = rst & grant1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      din_d        = din_q;
      sel_addr     = grant1 ? req1_addr : req0_addr;
      sel_data     = grant1 ? req1_data : req0_data;

      unique case (state_q)
         StRun: begin
            if (clr_req) begin
               // First sweep write goes out in the cycle after the request; cnt_q then
               // holds the next sweep address.
               state_d = StClear;
               we_d    = 1'b1;
               addr_d  = '0;
               din_d   = '0;
               cnt_d   = AW'(1);
            end else if (grant0 || grant1) begin
               last_grant_d = grant1;
               // A protected x0 write still completes its handshake but never reaches memory.
               if (!(ZERO_PROT && (sel_addr == '0))) begin
                  we_d   = 1'b1;
                  addr_d = sel_addr;
                  din_d  = sel_data;
               end
            end
         end
         StClear: begin
            if (addr_q == LastAddr) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               we_d   = 1'b1;
               addr_d = cnt_q;
               din_d  = '0;
               cnt_d  = cnt_q + AW'(1);
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StRun;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
      end
   end

   assign busy        = (state_q == StClear);
   assign clr_done    = busy && (addr_q == LastAddr);
   assign mem_we      = we_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_din  = din_q;

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single synchronous write port of the register-file memory block between two writers: the ALU writeback (req0) and the load/CSR writeback (req1).
- Uses round-robin arbitration with a valid/ready handshake.
- Drives registered write controls into the memory.
- Provides a sequenced synchronous clear that zeroes every entry one per cycle, as an alternative to the memory's asynchronous reset.
- Optionally drops writes to address 0, giving RV32I x0 semantics.

Parameters:
WIDTH, 32, data width of each memory entry
DEPTH, 32, number of entries; power of two, >= 2
ZERO_PROT, 1, 1 = writes to address 0 are accepted but never reach the memory; 0 = address 0 is writable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 has a write pending
req0_ready  output  1  requester 0 write accepted this cycle when high with req0_valid
req0_addr  input  $clog2(DEPTH)  requester 0 target address
req0_data  input  WIDTH  requester 0 write data
req1_valid  input  1  requester 1 has a write pending
req1_ready  output  1  requester 1 accept
req1_addr  input  $clog2(DEPTH)  requester 1 target address
req1_data  input  WIDTH  requester 1 write data
clr_req  input  1  single-cycle request to zero the whole memory
busy  output  1  clear sequence in progress
clr_done  output  1  one-cycle pulse coincident with the final clear write
mem_we  output  1  to memory we0
mem_wr_addr  output  $clog2(DEPTH)  to memory wr_addr0
mem_wr_din  output  WIDTH  to memory wr_din0

Behaviour:
- States:
  - RUN: normal arbitration.
  - CLEAR: sweep of all addresses.
- Reset (rst low), applied immediately and held while low:
  - state=RUN, last_grant=1 (requester 0 wins first contest), clear counter=0.
  - mem_we=0, mem_wr_addr=0, mem_wr_din=0, busy=0, clr_done=0.
  - req0_ready=req1_ready=0 (forced low while rst is low).
  - Reset mid-CLEAR aborts the sweep with no further writes.
- RUN arbitration (combinational ready):
  - If clr_req=1: both readys are 0 and no grant is made that cycle.
  - Else if exactly one valid: that requester's ready=1.
  - Else if both valid: ready goes to the requester that is not last_grant.
  - Ready never asserts without the matching valid.
  - At most one ready is high per cycle.
- Handshake:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - last_grant updates to the granted index.
  - Requesters hold addr/data stable while valid is high and not yet accepted.
- Write latency: a transfer accepted at edge N drives mem_we=1, mem_wr_addr/mem_wr_din = the accepted values for the cycle following N, so the memory commits at edge N+1.
  - Without a transfer, mem_we=0 next cycle.
  - mem_wr_addr/mem_wr_din hold their previous values when mem_we=0.
- Back-to-back: one write per cycle is sustained; both requesters continuously valid alternate 0,1,0,1,...
- ZERO_PROT=1 and accepted address=0:
  - The handshake completes normally and last_grant updates.
  - mem_we stays 0 for that slot.
- Clear sequence:
  - clr_req=1 in RUN sampled at edge N → CLEAR.
  - For the DEPTH cycles after N: mem_we=1, mem_wr_din=0, mem_wr_addr=0,1,…,DEPTH-1 in order.
  - busy=1 over exactly those cycles.
  - clr_done=1 only during the cycle driving address DEPTH-1.
  - Return to RUN at the edge ending that cycle; the counter resets to 0.
  - Address 0 is written during clear regardless of ZERO_PROT.
- During CLEAR:
  - Both readys are 0 and requesters stall; pending valids are served after return to RUN using the preserved last_grant.
  - clr_req is ignored.
- A write accepted in the cycle before clr_req is sampled still completes first: its mem_we slot precedes the sweep.

Test Plan:
- Single write: reset, then req0 addr=5 data=0xDEADBEEF valid for one cycle → req0_ready=1 same cycle; next cycle mem_we=1, addr=5, din=0xDEADBEEF; memory entry 5 reads 0xDEADBEEF.
- Contention: req0 and req1 both valid from cycle 0 for 4 transfers (addr 1,2 / 3,4) → grants in order 0,1,0,1; mem_we=1 four consecutive cycles with addresses 1,3,2,4.
- x0 protection: ZERO_PROT=1, req1 addr=0 data=0x12345678 → req1_ready=1, mem_we stays 0, entry 0 remains 0; with ZERO_PROT=0 → entry 0 = 0x12345678.
- Clear: fill entries with nonzero data, pulse clr_req with req0_valid=1 in the same cycle → ready low; busy high 32 cycles; addresses 0..31 written with 0; clr_done only in cycle with addr 31; req0 accepted in the first cycle after busy falls.
- Reset mid-clear: assert rst low at sweep address 10 → mem_we, busy, readys go 0 immediately; after release, state RUN, no further clear writes; first contest won by req0.
- Stall hold: req1 valid with addr=7 during CLEAR → req1_ready=0 throughout; accepted immediately after CLEAR; mem_we for addr 7 one cycle later.
